// File: rtl/riscv_instr_mem_responder.sv
// Instruction-fetch memory responder: preloadable word array behind a req/gnt
// address phase and an in-order response FIFO with per-entry latency countdown.
module riscv_instr_mem_responder #(
  parameter int          DEPTH_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          RESP_LATENCY    = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           instr_req_i,
  input  logic [31:0]                    instr_addr_i,
  output logic                           instr_gnt_o,
  output logic                           instr_rvalid_o,
  output logic [31:0]                    instr_rdata_o,
  output logic                           instr_err_o,
  input  logic                           gnt_stall_i,
  input  logic                           rsp_stall_i,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr_i,
  input  logic [31:0]                    wdata_i,
  output logic                           busy_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [2:0]       CD_INIT  = 3'(RESP_LATENCY - 1);
  localparam logic [32:0]      END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  logic [31:0]      mem    [DEPTH_WORDS];
  logic [IDX_W-1:0] idx_q  [MAX_OUTSTANDING];
  logic             err_q  [MAX_OUTSTANDING];
  logic [2:0]       cd_q   [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic push;
  logic pop;
  logic addr_err;
  logic head_valid;
  logic head_ready;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Address range check uses 33 bits so an array ending at 2^32 still works.
  assign addr_err   = ({1'b0, instr_addr_i} < {1'b0, BASE_ADDR}) |
                      ({1'b0, instr_addr_i} >= END_ADDR);
  assign head_valid = (count_q != '0);
  assign head_ready = (cd_q[rd_ptr_q] == 3'd0);

  // rst_n gates the handshake so nothing is granted or returned while in reset.
  assign pop         = rst_n & head_valid & head_ready & ~rsp_stall_i;
  assign push        = instr_gnt_o;
  assign instr_gnt_o = rst_n & instr_req_i & ~gnt_stall_i &
                       ((count_q < MAX_CNT) | pop);
  assign busy_o      = rst_n & head_valid;

  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_err_o    = 1'b0;
    instr_rdata_o  = '0;
    if (pop) begin
      instr_rvalid_o = 1'b1;
      instr_err_o    = err_q[rd_ptr_q];
      if (!err_q[rd_ptr_q]) begin
        instr_rdata_o = mem[idx_q[rd_ptr_q]];
      end
    end
  end

  // Countdowns run in every slot regardless of FIFO position; a fresh push reloads its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        idx_q[i] <= '0;
        err_q[i] <= 1'b0;
        cd_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (push && (PTR_W'(i) == wr_ptr_q)) begin
          idx_q[i] <= instr_addr_i[IDX_W+1:2];
          err_q[i] <= addr_err;
          cd_q[i]  <= CD_INIT;
        end else if (cd_q[i] != 3'd0) begin
          cd_q[i] <= cd_q[i] - 3'd1;
        end
      end
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Array is deliberately not reset; a same-cycle pop sees the pre-write word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: tb/tb_riscv_instr_mem_responder.sv
// Randomized and directed bench for riscv_instr_mem_responder; two instances
// (latency 1 and 3) checked every cycle against a queue-style reference model.
module tb_riscv_instr_mem_responder;

  localparam int          DEPTH = 16;
  localparam int          IDXW  = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [31:0] addr [2];
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [31:0] rdata [2];
  logic [1:0]  err;
  logic [1:0]  busy;
  logic        gnt_stall;
  logic        rsp_stall;
  logic        we;
  logic [3:0]  waddr;
  logic [31:0] wdata;

  int          total;
  int          bad;
  int          cyc;
  int          m_n     [2];
  int          m_head  [2];
  int          m_ready [2][4];
  logic [31:0] m_addr  [2][4];
  logic [31:0] ref_mem [DEPTH];
  logic [1:0]  last_gnt;
  logic [31:0] old_word;

  riscv_instr_mem_responder #(
    .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RESP_LATENCY(1), .MAX_OUTSTANDING(MAXO)
  ) dut_lat1 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req[0]), .instr_addr_i(addr[0]),
    .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]),
    .instr_err_o(err[0]), .gnt_stall_i(gnt_stall), .rsp_stall_i(rsp_stall),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .busy_o(busy[0])
  );

  riscv_instr_mem_responder #(
    .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RESP_LATENCY(3), .MAX_OUTSTANDING(MAXO)
  ) dut_lat3 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req[1]), .instr_addr_i(addr[1]),
    .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]),
    .instr_err_o(err[1]), .gnt_stall_i(gnt_stall), .rsp_stall_i(rsp_stall),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .busy_o(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic out_of_range(input logic [31:0] a);
    return (longint'(a) < longint'(BASE)) || (longint'(a) >= longint'(BASE) + 4 * DEPTH);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%h want=%h", tag, cyc, actual, expected);
    end
  endtask

  // Compares both instances at the falling edge, then advances the model one cycle.
  task automatic cycle();
    logic        pop_e;
    logic        gnt_e;
    logic        err_e;
    logic [31:0] data_e;
    logic [31:0] a;
    int          slot;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      pop_e  = 1'b0;
      err_e  = 1'b0;
      data_e = '0;
      if (rst_n && m_n[k] > 0 && cyc >= m_ready[k][m_head[k]] && !rsp_stall) begin
        pop_e  = 1'b1;
        a      = m_addr[k][m_head[k]];
        err_e  = out_of_range(a);
        data_e = err_e ? 32'h0 : ref_mem[a[IDXW+1:2]];
      end
      gnt_e = rst_n && req[k] && !gnt_stall && (m_n[k] < MAXO || pop_e);
      checkOutput($sformatf("gnt%0d", k),    32'(gnt[k]),    32'(gnt_e));
      checkOutput($sformatf("rvalid%0d", k), 32'(rvalid[k]), 32'(pop_e));
      checkOutput($sformatf("rdata%0d", k),  rdata[k],       data_e);
      checkOutput($sformatf("err%0d", k),    32'(err[k]),    32'(err_e));
      checkOutput($sformatf("busy%0d", k),   32'(busy[k]),   32'(rst_n && m_n[k] != 0));
      if (!rst_n) begin
        m_n[k]    = 0;
        m_head[k] = 0;
      end else begin
        if (pop_e) begin
          m_head[k] = (m_head[k] + 1) % 4;
          m_n[k]--;
        end
        if (gnt_e) begin
          slot             = (m_head[k] + m_n[k]) % 4;
          m_ready[k][slot] = cyc + lat_of(k);
          m_addr[k][slot]  = addr[k];
          m_n[k]++;
        end
      end
      last_gnt[k] = gnt_e;
    end
    if (we) ref_mem[waddr] = wdata;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic applyStimulus(input int n);
    logic [31:0] a;
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!req[k] || last_gnt[k]) begin
          req[k] = ($urandom_range(0, 3) != 0);
          a = BASE + 32'($urandom_range(0, 19)) * 4 + 32'($urandom_range(0, 3));
          if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(0, 255));
          addr[k] = a;
        end
      end
      gnt_stall = ($urandom_range(0, 3) == 0);
      rsp_stall = ($urandom_range(0, 3) == 0);
      we        = ($urandom_range(0, 3) == 0);
      waddr     = 4'($urandom_range(0, DEPTH - 1));
      wdata     = $urandom;
      rst_n     = ($urandom_range(0, 149) != 0);
      cycle();
    end
  endtask

  task automatic idle(input int n);
    req = 2'b00; gnt_stall = 1'b0; rsp_stall = 1'b0; we = 1'b0;
    for (int c = 0; c < n; c++) cycle();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; last_gnt = '0;
    for (int k = 0; k < 2; k++) begin m_n[k] = 0; m_head[k] = 0; end
    rst_n = 1'b0; req = 2'b11; addr[0] = BASE; addr[1] = BASE;
    gnt_stall = 1'b0; rsp_stall = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    cycle();
    #1 checkOutput("reset_gnt", 32'(gnt[0]), 32'h0);
    checkOutput("reset_busy", 32'(busy[0]), 32'h0);
    cycle();

    // Preload the array while idle.
    req = 2'b00; rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      we = 1'b1; waddr = 4'(i);
      wdata = (i == 0) ? 32'h0000_0013 : (i == 1) ? 32'h0040_006F : $urandom;
      cycle();
    end
    we = 1'b0;

    // Back-to-back fetch of words 0 and 1.
    req = 2'b11; addr[0] = BASE; addr[1] = BASE;
    #1 checkOutput("b2b_gnt_a", 32'(gnt[0]), 32'h1);
    cycle();
    addr[0] = BASE + 4; addr[1] = BASE + 4;
    #1 checkOutput("b2b_gnt_b", 32'(gnt[0]), 32'h1);
    checkOutput("b2b_data_a", rdata[0], 32'h0000_0013);
    cycle();
    req = 2'b00;
    #1 checkOutput("b2b_data_b", rdata[0], 32'h0040_006F);
    checkOutput("b2b_err_b", 32'(err[0]), 32'h0);
    idle(5);

    // First word past the array, and one word below the base.
    req = 2'b11; addr[0] = BASE + 4 * DEPTH; addr[1] = BASE + 4 * DEPTH;
    #1 checkOutput("oor_gnt", 32'(gnt[0]), 32'h1);
    cycle();
    addr[0] = BASE - 4; addr[1] = BASE - 4;
    #1 checkOutput("oor_err", 32'(err[0]), 32'h1);
    checkOutput("oor_rdata", rdata[0], 32'h0);
    cycle();
    req = 2'b00;
    #1 checkOutput("below_err", 32'(err[0]), 32'h1);
    idle(5);

    // Response stall fills the FIFO, then drains in order.
    rsp_stall = 1'b1; req = 2'b11; addr[0] = BASE + 8; addr[1] = BASE + 8;
    cycle(); cycle();
    #1 checkOutput("full_gnt", 32'(gnt[0]), 32'h0);
    checkOutput("full_busy", 32'(busy[0]), 32'h1);
    cycle();
    rsp_stall = 1'b0;
    #1 checkOutput("full_pop_gnt", 32'(gnt[0]), 32'h1);
    checkOutput("full_pop_rvalid", 32'(rvalid[0]), 32'h1);
    cycle();
    idle(6);

    // Grant stall for two cycles, then latency-3 response timing.
    gnt_stall = 1'b1; req = 2'b11; addr[0] = BASE + 12; addr[1] = BASE + 12;
    #1 checkOutput("gstall_a", 32'(gnt[1]), 32'h0);
    cycle();
    checkOutput("gstall_b", 32'(gnt[1]), 32'h0);
    cycle();
    gnt_stall = 1'b0;
    #1 checkOutput("gstall_release", 32'(gnt[1]), 32'h1);
    cycle();
    req = 2'b00;
    #1 checkOutput("lat3_c1", 32'(rvalid[1]), 32'h0);
    cycle();
    checkOutput("lat3_c2", 32'(rvalid[1]), 32'h0);
    cycle();
    checkOutput("lat3_c3", 32'(rvalid[1]), 32'h1);
    checkOutput("lat3_data", rdata[1], ref_mem[3]);
    cycle();
    idle(4);

    // Reset with entries outstanding discards them.
    rsp_stall = 1'b1; req = 2'b11; addr[0] = BASE; addr[1] = BASE;
    cycle(); cycle();
    req = 2'b00; rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; rsp_stall = 1'b0;
    #1 checkOutput("post_reset_busy", 32'(busy[0]), 32'h0);
    idle(5);
    req = 2'b11; addr[0] = BASE + 4; addr[1] = BASE + 4;
    cycle();
    req = 2'b00;
    #1 checkOutput("post_reset_fetch", rdata[0], 32'h0040_006F);
    idle(5);

    // Preload write colliding with a pop of the same word.
    req = 2'b01; addr[0] = BASE + 20;
    cycle();
    old_word = ref_mem[5];
    req = 2'b00; we = 1'b1; waddr = 4'd5; wdata = 32'hCAFE_F00D;
    #1 checkOutput("wr_same_old", rdata[0], old_word);
    cycle();
    we = 1'b0; req = 2'b01; addr[0] = BASE + 20;
    cycle();
    req = 2'b00;
    #1 checkOutput("wr_same_new", rdata[0], 32'hCAFE_F00D);
    idle(5);

    applyStimulus(1500);
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_instr_mem_responder.md
RISCV_INSTR_MEM_RESPONDER -- requirements
Module: riscv_instr_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the instruction array; power of two.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; aligned to 4*DEPTH_WORDS.
REQ-003 Parameter RESP_LATENCY, default 1: minimum number of cycles from grant to rvalid; range 1..8.
REQ-004 Parameter MAX_OUTSTANDING, default 2: response FIFO depth; range 1..4.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 instr_req_i  in  1  fetch request from the initiator.
REQ-008 instr_addr_i  in  32  fetch byte address; bits [1:0] ignored.
REQ-009 instr_gnt_o  out  1  address phase accepted, combinational.
REQ-010 instr_rvalid_o  out  1  response valid, one cycle per accepted request.
REQ-011 instr_rdata_o  out  32  response data.
REQ-012 instr_err_o  out  1  response error, qualified by instr_rvalid_o.
REQ-013 gnt_stall_i  in  1  bench/system grant back-pressure; blocks grant when 1.
REQ-014 rsp_stall_i  in  1  holds the FIFO head; blocks rvalid when 1.
REQ-015 we_i  in  1  preload write enable.
REQ-016 waddr_i  in  $clog2(DEPTH_WORDS)  preload word index.
REQ-017 wdata_i  in  32  preload data.
REQ-018 busy_o  out  1  at least one request outstanding.

Function
REQ-019 Handshake: transfer occurs in a cycle with instr_req_i=1 and instr_gnt_o=1; the initiator holds req/addr until granted.
REQ-020 instr_gnt_o = instr_req_i & ~gnt_stall_i & (count < MAX_OUTSTANDING | pop); pop is this cycle's response.
REQ-021 instr_gnt_o is never 1 while instr_req_i=0.
REQ-022 Push on transfer: entry {word address instr_addr_i[31:2], err flag, countdown = RESP_LATENCY-1}.
REQ-023 err flag = 1 when instr_addr_i < BASE_ADDR or instr_addr_i >= BASE_ADDR + 4*DEPTH_WORDS.
REQ-024 Each valid entry's countdown decrements by one per cycle while nonzero, independent of position.
REQ-025 pop = head valid & head countdown==0 & ~rsp_stall_i; instr_rvalid_o = pop.
REQ-026 When pop: instr_rdata_o = array[head word index] (combinational read), instr_err_o = head err; on err, instr_rdata_o = 0.
REQ-027 When ~pop: instr_rdata_o = 0, instr_err_o = 0.
REQ-028 Responses are strictly in request order; exactly one rvalid per grant.
REQ-029 Latency: grant in cycle c with FIFO empty and no stall gives rvalid in cycle c+RESP_LATENCY.
REQ-030 Back-to-back: with RESP_LATENCY=1 and no stalls, one grant and one rvalid per cycle sustained.
REQ-031 Simultaneous push and pop: count unchanged; with count==MAX_OUTSTANDING, grant is allowed only because pop=1.
REQ-032 Full: count==MAX_OUTSTANDING and no pop forces instr_gnt_o=0.
REQ-033 Empty: instr_rvalid_o=0 regardless of rsp_stall_i.
REQ-034 Preload write takes effect at the clock edge; a pop reading the same word in the write cycle returns the old data.
REQ-035 count is a saturating-free counter of width $clog2(MAX_OUTSTANDING+1); FIFO pointers wrap modulo MAX_OUTSTANDING.
REQ-036 busy_o = (count != 0).

Reset
REQ-037 While rst_n=0: FIFO empty, count=0, pointers=0, instr_gnt_o=0, instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, busy_o=0.
REQ-038 Reset asserted mid-transaction discards all outstanding entries; no rvalid is issued for them after reset release.
REQ-039 Array contents are not reset; preload is required before fetch.

Verification
REQ-040 Preload word 0=32'h0000_0013, word 1=32'h0040_006F; RESP_LATENCY=1; req addr 0 then 4 back-to-back -> gnt both cycles; rvalid in cycles c+1 and c+2 with 32'h0000_0013 and 32'h0040_006F; err=0.
REQ-041 Fetch from BASE_ADDR+4*DEPTH_WORDS -> gnt=1; rvalid after RESP_LATENCY cycles with err=1, rdata=0.
REQ-042 MAX_OUTSTANDING=2, rsp_stall_i=1, continuous req -> exactly 2 grants, then gnt=0, busy_o=1; release stall -> 2 in-order rvalids with gnt re-asserted in the first pop cycle.
REQ-043 RESP_LATENCY=3, single request at cycle 10 -> rvalid exactly at cycle 13; gnt_stall_i=1 for 2 cycles delays grant by 2 cycles, req held.
REQ-044 Assert rst_n=0 with 2 outstanding entries, release -> no rvalid ever appears for them; busy_o=0; next fetch behaves per REQ-029.
REQ-045 Same-cycle preload write of word 5 and pop of word 5 -> old value returned; next fetch of word 5 returns new value.
